rv32i_lsu: RTL and testbench

- Load/store unit between the RV32I core's execute stage and a word-wide data-memory bus with a valid/grant/response handshake.
- Accepts one memory operation at a time from the core: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Generates byte enables and lane-replicated write data, performs the bus transaction, and returns sign- or zero-extended load data.
- Flags misaligned accesses, bus errors and response timeouts; core stalls while core_ready is low.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 69 ++++++
 rtl/rv32i_lsu.sv | 160 ++++++++++++++++
 tb/tb_rv32i_lsu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting: store byte enables/replication and
// legality checks on the request side, load extraction on the response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_lane,
  output logic        req_misaligned,
  output logic        req_illegal,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_be         = BE_NONE;
    req_wdata_lane = '0;
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin
        req_be         = BE_BYTE << req_addr_lo;
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be         = req_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        req_wdata_lane = {2{req_wdata[15:0]}};
        req_misaligned = req_addr_lo[0];
      end
      2'b10: begin
        req_be         = BE_WORD;
        req_wdata_lane = req_wdata;
        req_misaligned = (req_addr_lo != 2'b00);
      end
      default: ;
    endcase
    // Loads always fetch the whole word; lanes are picked on the way back.
    if (!req_we) begin
      req_be         = BE_NONE;
      req_wdata_lane = '0;
    end
    if (req_we)
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
  end

  always_comb begin
    ld_byte  = rsp_rdata[{rsp_addr_lo, 3'b000} +: 8];
    ld_half  = rsp_rdata[{rsp_addr_lo[1], 4'b0000} +: 16];
    rsp_data = '0;
    case (rsp_funct3)
      F3_B:    rsp_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   rsp_data = {24'd0, ld_byte};
      F3_H:    rsp_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   rsp_data = {16'd0, ld_half};
      F3_W:    rsp_data = rsp_rdata;
      default: rsp_data = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one op at a time from execute to a word-wide
// valid/grant/response data bus, with misalign, bus-error and timeout reporting.
//
// state | meaning
// IDLE  | core_ready high, waiting for an op
// REQ   | bus_req high, bus fields held until grant
// WAIT  | granted, waiting for bus_rvalid
// RESP  | one-cycle rsp_valid pulse
module rv32i_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rsp_err_q, rsp_err_d, rsp_load;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] tmo_cnt_q;
  logic        tmo_hit, handshake, op_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lane, ld_data;
  logic        req_misaligned, req_illegal;

  lsu_align u_align (
    .req_we         (core_we),
    .req_funct3     (core_funct3),
    .req_addr_lo    (core_addr[1:0]),
    .req_wdata      (core_wdata),
    .req_be         (req_be),
    .req_wdata_lane (req_wdata_lane),
    .req_misaligned (req_misaligned),
    .req_illegal    (req_illegal),
    .rsp_funct3     (f3_q),
    .rsp_addr_lo    (alo_q),
    .rsp_rdata      (bus_rdata),
    .rsp_data       (ld_data)
  );

  assign handshake = core_valid && (state_q == IDLE);
  assign op_bad    = req_misaligned || req_illegal;
  // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && ((tmo_cnt_q + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (core_valid) begin
          if (op_bad) begin
            state_d   = RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (tmo_hit) begin
          state_d   = RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else if (bus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_d     = RESP;
          rsp_load    = 1'b1;
          rsp_err_d   = bus_err;
          rsp_rdata_d = (bus_err || we_q) ? 32'd0 : ld_data;
        end else if (tmo_hit) begin
          state_d   = RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_ready = (state_q == IDLE);
    bus_req    = (state_q == REQ);
    rsp_valid  = (state_q == RESP);
    rsp_err    = rsp_valid && rsp_err_q;
    rsp_rdata  = rsp_valid ? rsp_rdata_q : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (handshake) begin
        we_q    <= core_we;
        f3_q    <= core_funct3;
        alo_q   <= core_addr[1:0];
        addr_q  <= {core_addr[31:2], 2'b00};
        be_q    <= req_be;
        wdata_q <= req_wdata_lane;
      end
      if (rsp_load) begin
        rsp_err_q   <= rsp_err_d;
        rsp_rdata_q <= rsp_rdata_d;
      end
      if (state_q == REQ || state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 32'd1;
      else                                   tmo_cnt_q <= '0;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: formatting, error paths, stalls, timeout, reset abort.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_ready, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_assert = 0;
  int n_fail   = 0;

  rv32i_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .core_we     (core_we),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Zero-wait transaction: handshake cycle 0, grant cycle 1, rvalid cycle 2, response cycle 3.
  task automatic op_zw(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    check({tag, ":ready0"}, 32'(core_ready), 32'd1);
    core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    tick();
    core_valid = 1'b0;
    check({tag, ":req1"}, 32'(bus_req), 32'd1);
    check({tag, ":addr"}, bus_addr, {addr[31:2], 2'b00});
    check({tag, ":we"}, 32'(bus_we), 32'(we));
    check({tag, ":be"}, 32'(bus_be), 32'(exp_be));
    if (we) check({tag, ":wdata"}, bus_wdata, exp_wdata);
    check({tag, ":vld1"}, 32'(rsp_valid), 32'd0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check({tag, ":req2"}, 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = 1'b0;
    tick();
    bus_rvalid = 1'b0;
    check({tag, ":vld3"}, 32'(rsp_valid), 32'd1);
    check({tag, ":rdata"}, rsp_rdata, exp_rdata);
    check({tag, ":err"}, 32'(rsp_err), 32'd0);
    check({tag, ":ready3"}, 32'(core_ready), 32'd0);
    tick();
    check({tag, ":vld4"}, 32'(rsp_valid), 32'd0);
    check({tag, ":ready4"}, 32'(core_ready), 32'd1);
  endtask

  task automatic op_err(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = 32'h5A5A_5A5A;
    tick();
    core_valid = 1'b0;
    check({tag, ":vld1"}, 32'(rsp_valid), 32'd1);
    check({tag, ":err1"}, 32'(rsp_err), 32'd1);
    check({tag, ":rdata1"}, rsp_rdata, 32'd0);
    check({tag, ":req1"}, 32'(bus_req), 32'd0);
    tick();
    check({tag, ":vld2"}, 32'(rsp_valid), 32'd0);
    check({tag, ":ready2"}, 32'(core_ready), 32'd1);
    check({tag, ":req2"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b000; core_addr = '0; core_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    tick();
    tick();
    check("rst:ready", 32'(core_ready), 32'd1);
    check("rst:vld", 32'(rsp_valid), 32'd0);
    check("rst:err", 32'(rsp_err), 32'd0);
    check("rst:rdata", rsp_rdata, 32'd0);
    check("rst:req", 32'(bus_req), 32'd0);
    check("rst:we", 32'(bus_we), 32'd0);
    check("rst:be", 32'(bus_be), 32'd0);
    check("rst:addr", bus_addr, 32'd0);
    check("rst:wdata", bus_wdata, 32'd0);
    reset = 1'b0;
    tick();

    op_zw("lb",  1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 4'b0000, 32'd0, 32'hFFFF_FF80);
    op_zw("lhu", 1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'h8001_7FFF, 4'b0000, 32'd0, 32'h0000_8001);
    op_zw("lh",  1'b0, 3'b001, 32'h0000_0202, 32'd0, 32'h8001_7FFF, 4'b0000, 32'd0, 32'hFFFF_8001);
    op_zw("lbu", 1'b0, 3'b100, 32'h0000_0101, 32'd0, 32'h1234_F678, 4'b0000, 32'd0, 32'h0000_00F6);
    op_zw("sb",  1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 32'h5555_5555, 4'b0010, 32'hABAB_ABAB, 32'd0);
    op_zw("sh",  1'b1, 3'b001, 32'h0000_0302, 32'hFFFF_1234, 32'h5555_5555, 4'b1100, 32'h1234_1234, 32'd0);

    op_err("lw_mis", 1'b0, 3'b010, 32'h0000_0006);
    op_err("st_f3",  1'b1, 3'b011, 32'h0000_0400);
    op_err("lh_mis", 1'b0, 3'b001, 32'h0000_0203);

    // Grant withheld four cycles, then an erroring response.
    core_valid = 1'b1; core_we = 1'b1; core_funct3 = 3'b010; core_addr = 32'h0000_0504; core_wdata = 32'hCAFE_F00D;
    tick();
    core_valid = 1'b0;
    core_wdata = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      check("stall:req", 32'(bus_req), 32'd1);
      check("stall:addr", bus_addr, 32'h0000_0504);
      check("stall:we", 32'(bus_we), 32'd1);
      check("stall:be", 32'(bus_be), 32'hF);
      check("stall:wdata", bus_wdata, 32'hCAFE_F00D);
      tick();
    end
    bus_gnt = 1'b1;
    check("stall:req5", 32'(bus_req), 32'd1);
    tick();
    bus_gnt = 1'b0;
    check("stall:req6", 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; bus_err = 1'b1;
    tick();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    check("berr:vld", 32'(rsp_valid), 32'd1);
    check("berr:err", 32'(rsp_err), 32'd1);
    check("berr:rdata", rsp_rdata, 32'd0);
    tick();
    check("berr:vld_off", 32'(rsp_valid), 32'd0);

    // No grant ever: timeout after the eighth REQ cycle, late rvalid ignored.
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h0000_0600;
    tick();
    core_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("tmo:req", 32'(bus_req), 32'd1);
      check("tmo:vld_early", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("tmo:vld", 32'(rsp_valid), 32'd1);
    check("tmo:err", 32'(rsp_err), 32'd1);
    check("tmo:rdata", rsp_rdata, 32'd0);
    check("tmo:req_drop", 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    check("late:vld", 32'(rsp_valid), 32'd0);
    check("late:ready", 32'(core_ready), 32'd1);
    bus_rvalid = 1'b0;
    tick();
    check("late:vld2", 32'(rsp_valid), 32'd0);
    check("late:ready2", 32'(core_ready), 32'd1);

    // Reset while in WAIT aborts the transaction silently.
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h0000_0700;
    tick();
    core_valid = 1'b0;
    check("abort:req1", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check("abort:ready_wait", 32'(core_ready), 32'd0);
    reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    tick();
    reset = 1'b0; bus_rvalid = 1'b0;
    check("abort:req", 32'(bus_req), 32'd0);
    check("abort:ready", 32'(core_ready), 32'd1);
    check("abort:vld", 32'(rsp_valid), 32'd0);
    tick();
    check("abort:vld2", 32'(rsp_valid), 32'd0);

    op_zw("lw", 1'b0, 3'b010, 32'h0000_0800, 32'd0, 32'hDEAD_BEEF, 4'b0000, 32'd0, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
